// File: rtl/fsm_multi_stat.sv
// Multi-rule flow statistics: snoops the packet bus, parses the IPv4 TCP/UDP 5-tuple and
// keeps saturating byte/packet counters per masked rule, with a read / read-and-clear port.
module fsm_multi_stat #(
    parameter int RULE_NUM  = 4,
    parameter int BYTE_W    = 40,
    parameter int PKT_W     = 32,
    parameter int MULTI_HIT = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cnt_rst,
    input  logic [133:0]              pktin_data,
    input  logic                      pktin_data_wr,
    input  logic [104*RULE_NUM-1:0]   rule_5tuple,
    input  logic [104*RULE_NUM-1:0]   rule_mask,
    input  logic [RULE_NUM-1:0]       rule_en,
    input  logic                      cnt_rd_req,
    input  logic [3:0]                cnt_rd_idx,
    input  logic                      cnt_rd_clr,
    output logic                      cnt_rd_ack,
    output logic [BYTE_W-1:0]         cnt_rd_byte,
    output logic [PKT_W-1:0]          cnt_rd_pkt,
    output logic [31:0]               miss_pkt_num
);

    typedef enum logic [2:0] {
        S_IDLE, S_MD1, S_ETH, S_IP, S_L4, S_MATCH, S_WAIT_TAIL
    } state_t;

    state_t              state;
    logic                vlan;
    logic [11:0]         len;
    logic [103:0]        tuple;
    logic                tail_seen;

    logic                is_head;
    logic                is_tail;
    logic                ip_ok;
    logic                upd;
    logic [11:0]         byte_inc;
    logic [RULE_NUM-1:0] hit;
    logic [RULE_NUM-1:0] count_vec;
    logic                unused_bits;

    logic [BYTE_W-1:0]   byte_cnt [RULE_NUM];
    logic [PKT_W-1:0]    pkt_cnt  [RULE_NUM];
    logic [BYTE_W-1:0]   byte_nxt [RULE_NUM];
    logic [PKT_W-1:0]    pkt_nxt  [RULE_NUM];
    logic [BYTE_W-1:0]   rd_byte;
    logic [PKT_W-1:0]    rd_pkt;

    assign is_head     = pktin_data_wr && (pktin_data[133:132] == 2'b01);
    assign is_tail     = pktin_data_wr && (pktin_data[133:132] == 2'b10);
    assign unused_bits = ^pktin_data[131:128];

    // Tagged frames carry the inner ethertype in the IP beat, shifting the IPv4 header by 4 bytes.
    assign ip_ok = vlan ? ((pktin_data[127:112] == 16'h0800) &&
                           (pktin_data[39:32] == 8'h06 || pktin_data[39:32] == 8'h11))
                        : (pktin_data[71:64] == 8'h06 || pktin_data[71:64] == 8'h11);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            vlan      <= 1'b0;
            len       <= '0;
            tuple     <= '0;
            tail_seen <= 1'b0;
        end else if (is_head) begin
            state     <= S_MD1;
            len       <= pktin_data[107:96];
            vlan      <= 1'b0;
            tuple     <= '0;
            tail_seen <= 1'b0;
        end else begin
            if (is_tail)
                tail_seen <= 1'b1;
            case (state)
                S_IDLE: ;
                S_MD1: if (pktin_data_wr) state <= is_tail ? S_IDLE : S_ETH;
                S_ETH: if (pktin_data_wr) begin
                    if (is_tail) state <= S_IDLE;
                    else if (pktin_data[31:16] == 16'h8100) begin
                        vlan  <= 1'b1;
                        state <= S_IP;
                    end else if (pktin_data[31:16] == 16'h0800) begin
                        vlan  <= 1'b0;
                        state <= S_IP;
                    end else state <= S_WAIT_TAIL;
                end
                S_IP: if (pktin_data_wr) begin
                    if (is_tail) state <= S_IDLE;
                    else if (!ip_ok) state <= S_WAIT_TAIL;
                    else begin
                        if (vlan) begin
                            tuple[39:32]  <= pktin_data[39:32];
                            tuple[103:88] <= pktin_data[15:0];
                        end else begin
                            tuple[39:32]  <= pktin_data[71:64];
                            tuple[103:72] <= pktin_data[47:16];
                            tuple[71:56]  <= pktin_data[15:0];
                        end
                        state <= S_L4;
                    end
                end
                S_L4: if (pktin_data_wr) begin
                    if (is_tail) state <= S_IDLE;
                    else begin
                        if (vlan) begin
                            tuple[87:72] <= pktin_data[127:112];
                            tuple[71:40] <= pktin_data[111:80];
                            tuple[31:16] <= pktin_data[79:64];
                            tuple[15:0]  <= pktin_data[63:48];
                        end else begin
                            tuple[55:40] <= pktin_data[127:112];
                            tuple[31:16] <= pktin_data[111:96];
                            tuple[15:0]  <= pktin_data[95:80];
                        end
                        state <= S_MATCH;
                    end
                end
                S_MATCH:     state <= (tail_seen || is_tail) ? S_IDLE : S_WAIT_TAIL;
                S_WAIT_TAIL: if (is_tail) state <= S_IDLE;
                default:     state <= S_IDLE;
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        hit = '0;
        for (int i = 0; i < RULE_NUM; i++)
            hit[i] = rule_en[i] &&
                     (((tuple ^ rule_5tuple[104*i +: 104]) & rule_mask[104*i +: 104]) == '0);
    end

    // A head beat during MATCH aborts the packet, so it must not be counted.
    assign upd       = (state == S_MATCH) && !is_head && !cnt_rst;
    assign count_vec = (MULTI_HIT != 0) ? hit : (hit & (~hit + RULE_NUM'(1)));
    assign byte_inc  = (len > 12'd32) ? (len - 12'd32) : 12'd0;

    // Read-clear zeroes the base before the increment so a same-cycle update is never lost.
    always_comb begin : next_cnt
        logic [BYTE_W-1:0] byte_base;
        logic [PKT_W-1:0]  pkt_base;
        logic [BYTE_W:0]   byte_sum;
        for (int i = 0; i < RULE_NUM; i++) begin
            if (cnt_rd_req && cnt_rd_clr && (cnt_rd_idx == 4'(i))) begin
                byte_base = '0;
                pkt_base  = '0;
            end else begin
                byte_base = byte_cnt[i];
                pkt_base  = pkt_cnt[i];
            end
            byte_sum    = {1'b0, byte_base} + (BYTE_W+1)'(byte_inc);
            byte_nxt[i] = byte_base;
            pkt_nxt[i]  = pkt_base;
            if (upd && count_vec[i]) begin
                byte_nxt[i] = byte_sum[BYTE_W] ? '1 : byte_sum[BYTE_W-1:0];
                pkt_nxt[i]  = (pkt_base == '1) ? pkt_base : pkt_base + PKT_W'(1);
            end
            if (cnt_rst) begin
                byte_nxt[i] = '0;
                pkt_nxt[i]  = '0;
            end
        end
    end

    // NOTE: the counter arrays are reset because they are architectural state read by software.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RULE_NUM; i++) begin
                byte_cnt[i] <= '0;
                pkt_cnt[i]  <= '0;
            end
            miss_pkt_num <= '0;
        end else begin
            for (int i = 0; i < RULE_NUM; i++) begin
                byte_cnt[i] <= byte_nxt[i];
                pkt_cnt[i]  <= pkt_nxt[i];
            end
            if (cnt_rst)
                miss_pkt_num <= '0;
            else if (upd && (hit == '0) && (miss_pkt_num != '1))
                miss_pkt_num <= miss_pkt_num + 32'd1;
        end
    end

    // Out-of-range indices fall through the mux and read as zero.
    always_comb begin
        rd_byte = '0;
        rd_pkt  = '0;
        for (int i = 0; i < RULE_NUM; i++) begin
            if (cnt_rd_idx == 4'(i)) begin
                rd_byte = byte_cnt[i];
                rd_pkt  = pkt_cnt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_rd_ack  <= 1'b0;
            cnt_rd_byte <= '0;
            cnt_rd_pkt  <= '0;
        end else begin
            cnt_rd_ack <= cnt_rd_req;
            if (cnt_rd_req) begin
                cnt_rd_byte <= cnt_rst ? '0 : rd_byte;
                cnt_rd_pkt  <= cnt_rst ? '0 : rd_pkt;
            end
        end
    end

endmodule

// File: tb/tb_fsm_multi_stat.sv
// Directed bench for fsm_multi_stat: a default instance (lowest-hit) and a narrow-counter
// multi-hit instance share the packet bus, each with its own beat strobe and read request.
module tb_fsm_multi_stat;

    localparam logic [103:0] T_UDP  = {32'h0A000001, 32'h0A000002, 8'h11, 16'h1234, 16'h5678};
    localparam logic [103:0] T_TCP  = {32'h0A000001, 32'h0A000002, 8'h06, 16'h1234, 16'h5678};
    localparam logic [103:0] T_ICMP = {32'h0A000001, 32'h0A000002, 8'h01, 16'h1234, 16'h5678};
    localparam logic [103:0] T_MISS = {32'h0A000001, 32'h0A000002, 8'h11, 16'h1234, 16'h9999};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cnt_rst = 1'b0;
    logic [133:0] pktin_data = '0;
    logic         wr0 = 1'b0, wr1 = 1'b0;
    logic [415:0] rule_5tuple, rule_mask;
    logic [3:0]   rule_en;
    logic         rd_req0 = 1'b0, rd_req1 = 1'b0;
    logic [3:0]   rd_idx = '0;
    logic         rd_clr = 1'b0;

    logic         ack0, ack1;
    logic [39:0]  byte0;
    logic [31:0]  pkt0;
    logic [11:0]  byte1;
    logic [1:0]   pkt1;
    logic [31:0]  miss0, miss1;

    int           checks = 0;
    int           errors = 0;
    logic         r_ack;
    logic [39:0]  r_byte;
    logic [31:0]  r_pkt;

    fsm_multi_stat dut0 (
        .clk(clk), .rst_n(rst_n), .cnt_rst(cnt_rst),
        .pktin_data(pktin_data), .pktin_data_wr(wr0),
        .rule_5tuple(rule_5tuple), .rule_mask(rule_mask), .rule_en(rule_en),
        .cnt_rd_req(rd_req0), .cnt_rd_idx(rd_idx), .cnt_rd_clr(rd_clr),
        .cnt_rd_ack(ack0), .cnt_rd_byte(byte0), .cnt_rd_pkt(pkt0),
        .miss_pkt_num(miss0)
    );

    fsm_multi_stat #(.RULE_NUM(4), .BYTE_W(12), .PKT_W(2), .MULTI_HIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cnt_rst(cnt_rst),
        .pktin_data(pktin_data), .pktin_data_wr(wr1),
        .rule_5tuple(rule_5tuple), .rule_mask(rule_mask), .rule_en(rule_en),
        .cnt_rd_req(rd_req1), .cnt_rd_idx(rd_idx), .cnt_rd_clr(rd_clr),
        .cnt_rd_ack(ack1), .cnt_rd_byte(byte1), .cnt_rd_pkt(pkt1),
        .miss_pkt_num(miss1)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [133:0] mk_beat(input logic [1:0] kind);
        logic [133:0] d = '0;
        d[133:132] = kind;
        return d;
    endfunction

    function automatic logic [133:0] mk_head(input logic [11:0] len);
        logic [133:0] d = mk_beat(2'b01);
        d[107:96] = len;
        return d;
    endfunction

    function automatic logic [133:0] mk_eth(input logic [15:0] etype);
        logic [133:0] d = mk_beat(2'b11);
        d[31:16] = etype;
        return d;
    endfunction

    function automatic logic [133:0] mk_ip(input bit vlan, input logic [103:0] t);
        logic [133:0] d = mk_beat(2'b11);
        if (vlan) begin
            d[127:112] = 16'h0800;
            d[39:32]   = t[39:32];
            d[15:0]    = t[103:88];
        end else begin
            d[71:64] = t[39:32];
            d[47:16] = t[103:72];
            d[15:0]  = t[71:56];
        end
        return d;
    endfunction

    function automatic logic [133:0] mk_l4(input bit vlan, input logic [103:0] t);
        logic [133:0] d = mk_beat(2'b11);
        if (vlan) begin
            d[127:112] = t[87:72];
            d[111:80]  = t[71:40];
            d[79:64]   = t[31:16];
            d[63:48]   = t[15:0];
        end else begin
            d[127:112] = t[55:40];
            d[111:96]  = t[31:16];
            d[95:80]   = t[15:0];
        end
        return d;
    endfunction

    task automatic beat(input bit sel, input logic [133:0] d);
        pktin_data = d;
        wr0 = !sel;
        wr1 = sel;
        @(posedge clk);
        #1;
        wr0 = 1'b0;
        wr1 = 1'b0;
    endtask

    // mode 0: full packet, tail in MATCH cycle; 1: tail replaces L4 beat;
    // 2: stop after IP beat (parser left in L4); 3: stop after L4 beat (parser in MATCH).
    task automatic send_pkt(input bit sel, input bit vlan, input logic [15:0] etype,
                            input logic [11:0] len, input logic [103:0] t, input int mode);
        beat(sel, mk_head(len));
        beat(sel, mk_beat(2'b11));
        beat(sel, mk_eth(vlan ? 16'h8100 : etype));
        beat(sel, mk_ip(vlan, t));
        if (mode == 1) begin
            beat(sel, mk_beat(2'b10));
            return;
        end
        if (mode == 2) return;
        beat(sel, mk_l4(vlan, t));
        if (mode == 3) return;
        beat(sel, mk_beat(2'b10));
    endtask

    task automatic do_read(input bit sel, input logic [3:0] idx, input bit clr);
        rd_req0 = !sel;
        rd_req1 = sel;
        rd_idx  = idx;
        rd_clr  = clr;
        @(posedge clk);
        #1;
        rd_req0 = 1'b0;
        rd_req1 = 1'b0;
        rd_clr  = 1'b0;
        r_ack   = sel ? ack1 : ack0;
        r_byte  = sel ? {28'd0, byte1} : byte0;
        r_pkt   = sel ? {30'd0, pkt1} : pkt0;
    endtask

    task automatic test_reset;
        checks++;
        if (ack0 !== 1'b0 || miss0 !== 32'd0 || byte0 !== 40'd0 || pkt0 !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%0b miss=%0d byte=%0d pkt=%0d, want all 0",
                     ack0, miss0, byte0, pkt0);
        end
        do_read(0, 4'd0, 1'b0);
        checks++;
        if (r_ack !== 1'b1 || r_pkt !== 32'd0 || r_byte !== 40'd0) begin
            errors++;
            $display("FAIL reset_read0: ack=%0b pkt=%0d byte=%0d, want 1/0/0", r_ack, r_pkt, r_byte);
        end
    endtask

    task automatic test_untagged_udp;
        send_pkt(0, 1'b0, 16'h0800, 12'h05E, T_UDP, 0);
        do_read(0, 4'd0, 1'b0);
        checks++;
        if (r_ack !== 1'b1 || r_pkt !== 32'd1 || r_byte !== 40'd62 || miss0 !== 32'd0) begin
            errors++;
            $display("FAIL udp_rule0: ack=%0b pkt=%0d byte=%0d miss=%0d, want 1/1/62/0",
                     r_ack, r_pkt, r_byte, miss0);
        end
    endtask

    task automatic test_tagged_tcp;
        send_pkt(0, 1'b1, 16'h0800, 12'h062, T_TCP, 0);
        do_read(0, 4'd1, 1'b0);
        checks++;
        if (r_pkt !== 32'd1 || r_byte !== 40'd66) begin
            errors++;
            $display("FAIL tcp_rule1: pkt=%0d byte=%0d, want 1/66", r_pkt, r_byte);
        end
        do_read(0, 4'd0, 1'b0);
        checks++;
        if (r_pkt !== 32'd1 || r_byte !== 40'd62 || miss0 !== 32'd0) begin
            errors++;
            $display("FAIL tcp_rule0_untouched: pkt=%0d byte=%0d miss=%0d, want 1/62/0",
                     r_pkt, r_byte, miss0);
        end
    endtask

    task automatic test_non_ip_and_miss;
        send_pkt(0, 1'b0, 16'h0806, 12'h05E, T_UDP, 0);
        send_pkt(0, 1'b0, 16'h0800, 12'h05E, T_ICMP, 0);
        do_read(0, 4'd0, 1'b0);
        checks++;
        if (r_pkt !== 32'd1 || r_byte !== 40'd62 || miss0 !== 32'd0) begin
            errors++;
            $display("FAIL arp_icmp_ignored: pkt=%0d byte=%0d miss=%0d, want 1/62/0",
                     r_pkt, r_byte, miss0);
        end
        send_pkt(0, 1'b0, 16'h0800, 12'h05E, T_UDP, 0);
        send_pkt(0, 1'b0, 16'h0800, 12'h040, T_MISS, 0);
        send_pkt(0, 1'b0, 16'h0800, 12'h014, T_UDP, 0);
        do_read(0, 4'd0, 1'b0);
        checks++;
        if (r_pkt !== 32'd3 || r_byte !== 40'd124 || miss0 !== 32'd1) begin
            errors++;
            $display("FAIL miss_and_short: pkt=%0d byte=%0d miss=%0d, want 3/124/1",
                     r_pkt, r_byte, miss0);
        end
    endtask

    task automatic test_multi_hit;
        rule_en = 4'b0111;
        send_pkt(0, 1'b0, 16'h0800, 12'h05E, T_UDP, 0);
        send_pkt(1, 1'b0, 16'h0800, 12'h05E, T_UDP, 0);
        rule_en = 4'b0011;
        do_read(0, 4'd0, 1'b0);
        checks++;
        if (r_pkt !== 32'd4 || r_byte !== 40'd186) begin
            errors++;
            $display("FAIL lowhit_rule0: pkt=%0d byte=%0d, want 4/186", r_pkt, r_byte);
        end
        do_read(0, 4'd2, 1'b0);
        checks++;
        if (r_pkt !== 32'd0 || r_byte !== 40'd0) begin
            errors++;
            $display("FAIL lowhit_rule2: pkt=%0d byte=%0d, want 0/0", r_pkt, r_byte);
        end
        do_read(1, 4'd0, 1'b0);
        checks++;
        if (r_pkt !== 32'd1 || r_byte !== 40'd62) begin
            errors++;
            $display("FAIL multihit_rule0: pkt=%0d byte=%0d, want 1/62", r_pkt, r_byte);
        end
        do_read(1, 4'd2, 1'b0);
        checks++;
        if (r_pkt !== 32'd1 || r_byte !== 40'd62 || miss1 !== 32'd0) begin
            errors++;
            $display("FAIL multihit_rule2: pkt=%0d byte=%0d miss=%0d, want 1/62/0",
                     r_pkt, r_byte, miss1);
        end
    endtask

    task automatic test_read_clear;
        do_read(0, 4'd0, 1'b1);
        checks++;
        if (r_pkt !== 32'd4 || r_byte !== 40'd186) begin
            errors++;
            $display("FAIL rdclr_value: pkt=%0d byte=%0d, want 4/186", r_pkt, r_byte);
        end
        do_read(0, 4'd0, 1'b0);
        checks++;
        if (r_pkt !== 32'd0 || r_byte !== 40'd0) begin
            errors++;
            $display("FAIL rdclr_zeroed: pkt=%0d byte=%0d, want 0/0", r_pkt, r_byte);
        end
        for (int k = 0; k < 5; k++)
            send_pkt(0, 1'b0, 16'h0800, 12'h084, T_UDP, 0);
        send_pkt(0, 1'b0, 16'h0800, 12'h060, T_UDP, 3);
        do_read(0, 4'd0, 1'b1);
        checks++;
        if (r_ack !== 1'b1 || r_pkt !== 32'd5 || r_byte !== 40'd500) begin
            errors++;
            $display("FAIL clr_in_match_read: ack=%0b pkt=%0d byte=%0d, want 1/5/500",
                     r_ack, r_pkt, r_byte);
        end
        beat(0, mk_beat(2'b10));
        do_read(0, 4'd0, 1'b0);
        checks++;
        if (r_pkt !== 32'd1 || r_byte !== 40'd64) begin
            errors++;
            $display("FAIL clr_in_match_after: pkt=%0d byte=%0d, want 1/64", r_pkt, r_byte);
        end
    endtask

    task automatic test_back_to_back_reads;
        do_read(0, 4'd1, 1'b0);
        checks++;
        if (r_ack !== 1'b1 || r_pkt !== 32'd1 || r_byte !== 40'd66) begin
            errors++;
            $display("FAIL b2b_idx1: ack=%0b pkt=%0d byte=%0d, want 1/1/66", r_ack, r_pkt, r_byte);
        end
        do_read(0, 4'd4, 1'b0);
        checks++;
        if (r_ack !== 1'b1 || r_pkt !== 32'd0 || r_byte !== 40'd0) begin
            errors++;
            $display("FAIL b2b_idx4: ack=%0b pkt=%0d byte=%0d, want 1/0/0", r_ack, r_pkt, r_byte);
        end
        do_read(0, 4'd15, 1'b0);
        checks++;
        if (r_ack !== 1'b1 || r_pkt !== 32'd0 || r_byte !== 40'd0) begin
            errors++;
            $display("FAIL b2b_idx15: ack=%0b pkt=%0d byte=%0d, want 1/0/0", r_ack, r_pkt, r_byte);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ack0 !== 1'b0) begin
            errors++;
            $display("FAIL ack_pulse: ack=%0b one cycle after last request, want 0", ack0);
        end
    endtask

    task automatic test_saturation;
        do_read(1, 4'd0, 1'b1);
        send_pkt(1, 1'b0, 16'h0800, 12'hFFF, T_UDP, 0);
        send_pkt(1, 1'b0, 16'h0800, 12'h037, T_UDP, 0);
        do_read(1, 4'd0, 1'b0);
        checks++;
        if (r_pkt !== 32'd2 || r_byte !== 40'd4086) begin
            errors++;
            $display("FAIL sat_preload: pkt=%0d byte=%0d, want 2/4086", r_pkt, r_byte);
        end
        send_pkt(1, 1'b0, 16'h0800, 12'h040, T_UDP, 0);
        do_read(1, 4'd0, 1'b0);
        checks++;
        if (r_pkt !== 32'd3 || r_byte !== 40'd4095) begin
            errors++;
            $display("FAIL sat_byte: pkt=%0d byte=%0d, want 3/4095", r_pkt, r_byte);
        end
        send_pkt(1, 1'b0, 16'h0800, 12'h040, T_UDP, 0);
        do_read(1, 4'd0, 1'b0);
        checks++;
        if (r_pkt !== 32'd3 || r_byte !== 40'd4095) begin
            errors++;
            $display("FAIL sat_pkt: pkt=%0d byte=%0d, want 3/4095", r_pkt, r_byte);
        end
    endtask

    task automatic test_abort;
        do_read(1, 4'd0, 1'b1);
        send_pkt(1, 1'b0, 16'h0800, 12'h040, T_UDP, 2);
        send_pkt(1, 1'b0, 16'h0800, 12'h050, T_UDP, 0);
        do_read(1, 4'd0, 1'b0);
        checks++;
        if (r_pkt !== 32'd1 || r_byte !== 40'd48) begin
            errors++;
            $display("FAIL head_abort: pkt=%0d byte=%0d, want 1/48", r_pkt, r_byte);
        end
        send_pkt(1, 1'b0, 16'h0800, 12'h050, T_UDP, 1);
        do_read(1, 4'd0, 1'b0);
        checks++;
        if (r_pkt !== 32'd1 || r_byte !== 40'd48 || miss1 !== 32'd0) begin
            errors++;
            $display("FAIL tail_abort: pkt=%0d byte=%0d miss=%0d, want 1/48/0",
                     r_pkt, r_byte, miss1);
        end
    endtask

    task automatic test_cnt_rst;
        cnt_rst = 1'b1;
        do_read(0, 4'd1, 1'b0);
        checks++;
        if (r_ack !== 1'b1 || r_pkt !== 32'd0 || r_byte !== 40'd0) begin
            errors++;
            $display("FAIL cnt_rst_read: ack=%0b pkt=%0d byte=%0d, want 1/0/0", r_ack, r_pkt, r_byte);
        end
        send_pkt(0, 1'b0, 16'h0800, 12'h05E, T_UDP, 0);
        cnt_rst = 1'b0;
        do_read(0, 4'd0, 1'b0);
        checks++;
        if (r_pkt !== 32'd0 || r_byte !== 40'd0 || miss0 !== 32'd0) begin
            errors++;
            $display("FAIL cnt_rst_no_update: pkt=%0d byte=%0d miss=%0d, want 0/0/0",
                     r_pkt, r_byte, miss0);
        end
        send_pkt(0, 1'b0, 16'h0800, 12'h05E, T_UDP, 0);
        do_read(0, 4'd0, 1'b0);
        checks++;
        if (r_pkt !== 32'd1 || r_byte !== 40'd62) begin
            errors++;
            $display("FAIL cnt_rst_resume: pkt=%0d byte=%0d, want 1/62", r_pkt, r_byte);
        end
    endtask

    task automatic test_async_reset;
        send_pkt(0, 1'b0, 16'h0800, 12'h05E, T_UDP, 2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        beat(0, mk_l4(1'b0, T_UDP));
        beat(0, mk_beat(2'b10));
        do_read(0, 4'd0, 1'b0);
        checks++;
        if (r_pkt !== 32'd0 || r_byte !== 40'd0 || miss0 !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_drop: pkt=%0d byte=%0d miss=%0d, want 0/0/0",
                     r_pkt, r_byte, miss0);
        end
        send_pkt(0, 1'b0, 16'h0800, 12'h05E, T_UDP, 0);
        do_read(0, 4'd0, 1'b0);
        checks++;
        if (r_pkt !== 32'd1 || r_byte !== 40'd62) begin
            errors++;
            $display("FAIL async_reset_resume: pkt=%0d byte=%0d, want 1/62", r_pkt, r_byte);
        end
    endtask

    initial begin
        rule_5tuple = '0;
        rule_mask   = '0;
        rule_5tuple[103:0]   = T_UDP;
        rule_mask[103:0]     = '1;
        rule_5tuple[207:104] = {64'h0, 8'h06, 32'h0};
        rule_mask[207:104]   = {64'h0, 8'hFF, 32'h0};
        rule_5tuple[311:208] = {32'h0A000001, 72'h0};
        rule_mask[311:208]   = {32'hFFFFFFFF, 72'h0};
        rule_en = 4'b0011;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        test_reset();
        test_untagged_udp();
        test_tagged_tcp();
        test_non_ip_and_miss();
        test_multi_hit();
        test_read_clear();
        test_back_to_back_reads();
        test_saturation();
        test_abort();
        test_cnt_rst();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
